// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and helpers used by the IF-stage blocks,
// the direction predictor and the ID-stage check.
package mips_pkg;

   localparam int unsigned PC_W = 32;

   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_JAL = 6'b000011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;

   localparam int unsigned OPC_HI = 31;
   localparam int unsigned OPC_LO = 26;
   localparam int unsigned IDX_HI = 25;
   localparam int unsigned IDX_LO = 0;
   localparam int unsigned IMM_HI = 15;
   localparam int unsigned IMM_LO = 0;

   // Sign-extended word offset of a branch immediate, already in byte units.
   function automatic logic [PC_W-1:0] imm_word_offset(input logic [15:0] imm);
      return {{(PC_W-18){imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// IF-stage fetch/predict/check signals shared between the PC unit and the pipeline.
interface fetch_pc_unit_if;
   import mips_pkg::*;

   logic            stall;
   logic [31:0]     If_Inst;
   logic            predTaken;
   logic            predWrong;
   logic [PC_W-1:0] If_PC;
   logic            IfId_PredTaken;
   logic            flush;

   modport slave (
      input  stall, If_Inst, predTaken, predWrong,
      output If_PC, IfId_PredTaken, flush
   );

   modport master (
      output stall, If_Inst, predTaken, predWrong,
      input  If_PC, IfId_PredTaken, flush
   );

endinterface

// File: rtl/fetch_target_calc.sv
// Combinational address generator: sequential, branch and jump targets plus
// branch/jump classification of the instruction in IF.
module fetch_target_calc
   import mips_pkg::*;
(
   input  logic [PC_W-1:0] pc,
   input  logic [31:0]     inst,
   output logic [PC_W-1:0] seq,
   output logic [PC_W-1:0] btgt,
   output logic [PC_W-1:0] jtgt,
   output logic            is_branch,
   output logic            is_jump
);

   logic [5:0] opcode;

   always_comb begin
      opcode    = inst[OPC_HI:OPC_LO];
      seq       = pc + 32'd4;
      btgt      = seq + imm_word_offset(inst[IMM_HI:IMM_LO]);
      jtgt      = {seq[31:28], inst[IDX_HI:IDX_LO], 2'b00};
      is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
      is_jump   = (opcode == OP_J)   || (opcode == OP_JAL);
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage next-PC generator with one-cycle mispredict recovery and
// saturating branch/mispredict counters.
module fetch_pc_unit
   import mips_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned     CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   fetch_pc_unit_if.slave   fif,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   logic [PC_W-1:0]  pc_q, pc_d;
   logic [PC_W-1:0]  alt_q, alt_d;
   logic             pend_q, pend_d;
   logic             pt_q, pt_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   logic [PC_W-1:0]  seq, btgt, jtgt;
   logic             is_branch, is_jump;
   logic             resolve, flush;

   fetch_target_calc u_tgt (
      .pc        (pc_q),
      .inst      (fif.If_Inst),
      .seq       (seq),
      .btgt      (btgt),
      .jtgt      (jtgt),
      .is_branch (is_branch),
      .is_jump   (is_jump)
   );

   always_comb begin
      resolve    = pend_q & ~fif.stall;
      flush      = resolve & fif.predWrong;

      pc_d       = pc_q;
      alt_d      = alt_q;
      pend_d     = pend_q;
      pt_d       = pt_q;
      br_cnt_d   = br_cnt_q;
      miss_cnt_d = miss_cnt_q;

      if (resolve && (br_cnt_q != '1))
         br_cnt_d = br_cnt_q + CNT_W'(1);
      if (flush && (miss_cnt_q != '1))
         miss_cnt_d = miss_cnt_q + CNT_W'(1);

      // A flush wins over everything, including capture of a branch now in IF.
      if (flush) begin
         pc_d   = alt_q;
         pend_d = 1'b0;
         pt_d   = 1'b0;
      end else if (!fif.stall) begin
         if (is_jump)
            pc_d = jtgt;
         else if (is_branch && fif.predTaken)
            pc_d = btgt;
         else
            pc_d = seq;

         pend_d = is_branch;
         pt_d   = is_branch & fif.predTaken;
         if (is_branch)
            alt_d = fif.predTaken ? seq : btgt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         alt_q      <= '0;
         pend_q     <= 1'b0;
         pt_q       <= 1'b0;
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         pc_q       <= pc_d;
         alt_q      <= alt_d;
         pend_q     <= pend_d;
         pt_q       <= pt_d;
         br_cnt_q   <= br_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign fif.If_PC          = pc_q;
   assign fif.IfId_PredTaken = pt_q;
   assign fif.flush          = flush;
   assign br_cnt             = br_cnt_q;
   assign miss_cnt           = miss_cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized and directed bench for fetch_pc_unit against a cycle-level
// behavioural model of the fetch/predict/recover rules.
module tb_fetch_pc_unit;

   localparam int unsigned CW   = 10;
   localparam logic [31:0] RPC  = 32'h0000_0000;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] br_cnt, miss_cnt;

   fetch_pc_unit_if fif ();

   fetch_pc_unit #(.RESET_PC(RPC), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .fif      (fif.slave),
      .br_cnt   (br_cnt),
      .miss_cnt (miss_cnt)
   );

   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   logic [31:0] m_pc, m_alt;
   bit          m_pend, m_ptq;
   int unsigned m_br, m_miss;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      m_pc = RPC; m_alt = 32'h0; m_pend = 0; m_ptq = 0; m_br = 0; m_miss = 0;
   endtask

   function automatic logic [31:0] mk_br(input bit bne, input logic [15:0] imm);
      return {(bne ? 6'd5 : 6'd4), 10'd0, imm};
   endfunction

   // Drive one cycle, check outputs against the model, then advance model and clock.
   task automatic step(input bit s, input logic [31:0] inst, input bit pt, input bit pw);
      logic [31:0] seq, btgt, jtgt;
      int unsigned op;
      bit isb, isj, fl;
      fif.stall = s; fif.If_Inst = inst; fif.predTaken = pt; fif.predWrong = pw;
      #2;
      fl = m_pend && !s && pw;
      chk("flush", {31'd0, fif.flush}, {31'd0, fl});
      chk("if_pc", fif.If_PC, m_pc);
      chk("ifid_pt", {31'd0, fif.IfId_PredTaken}, {31'd0, m_ptq});
      chk("br_cnt", 32'(br_cnt), m_br);
      chk("miss_cnt", 32'(miss_cnt), m_miss);

      op   = inst[31:26];
      isb  = (op == 4) || (op == 5);
      isj  = (op == 2) || (op == 3);
      seq  = m_pc + 32'd4;
      btgt = seq + 32'(int'($signed(inst[15:0])) * 4);
      jtgt = (seq & 32'hF000_0000) | (32'(inst[25:0]) * 4);

      if (m_pend && !s) begin
         if (m_br < CMAX) m_br++;
         if (pw && m_miss < CMAX) m_miss++;
      end
      if (fl) begin
         m_pc = m_alt; m_pend = 0; m_ptq = 0;
      end else if (!s) begin
         m_pc   = isj ? jtgt : (isb && pt) ? btgt : seq;
         m_pend = isb;
         m_ptq  = isb && pt;
         if (isb) m_alt = pt ? seq : btgt;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic nop(input bit pw);
      step(0, 32'h0, 0, pw);
   endtask

   task automatic run_to(input logic [31:0] target);
      for (int i = 0; i < 400 && m_pc != target; i++) nop(0);
      chk("reach_pc", fif.If_PC, target);
   endtask

   task automatic mid_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_pc", fif.If_PC, RPC);
      chk("rst_br", 32'(br_cnt), 32'd0);
      chk("rst_miss", 32'(miss_cnt), 32'd0);
      chk("rst_pt", {31'd0, fif.IfId_PredTaken}, 32'd0);
      chk("rst_flush", {31'd0, fif.flush}, 32'd0);
      #2 rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [31:0] inst;
      rst = 1'b1;
      fif.stall = 0; fif.If_Inst = 0; fif.predTaken = 0; fif.predWrong = 1;
      model_reset();
      #12;
      chk("init_pc", fif.If_PC, RPC);
      chk("init_flush", {31'd0, fif.flush}, 32'd0);
      rst = 1'b0;

      // Predicted-taken BEQ, correct
      run_to(32'h10);
      step(0, mk_br(0, 16'h0003), 1, 0);
      chk("beq_tgt", fif.If_PC, 32'h20);
      chk("beq_pt", {31'd0, fif.IfId_PredTaken}, 32'd1);
      nop(0);
      chk("beq_br", 32'(br_cnt), 32'd1);
      chk("beq_miss", 32'(miss_cnt), 32'd0);

      // Predicted-not-taken BNE, wrong
      run_to(32'h40);
      step(0, mk_br(1, 16'hFFFE), 0, 0);
      chk("bne_seq", fif.If_PC, 32'h44);
      nop(1);
      chk("bne_recover", fif.If_PC, 32'h3C);
      chk("bne_miss", 32'(miss_cnt), 32'd1);

      // Stall during resolve, then a single flush
      step(0, mk_br(0, 16'h0001), 1, 0);
      step(1, 32'h0, 0, 1);
      step(1, 32'h0, 0, 1);
      chk("stall_pc", fif.If_PC, 32'h44);
      chk("stall_br", 32'(br_cnt), 32'd2);
      nop(1);
      chk("stall_recover", fif.If_PC, 32'h40);
      nop(1);

      // J to self, then flush colliding with a new branch in IF
      run_to(32'h100);
      step(0, {6'd2, 26'h40}, 0, 0);
      chk("j_tgt", fif.If_PC, 32'h100);
      step(0, mk_br(0, 16'h0005), 0, 0);
      step(0, mk_br(1, 16'h0010), 1, 1);
      chk("coll_pc", fif.If_PC, 32'h118);
      chk("coll_pt", {31'd0, fif.IfId_PredTaken}, 32'd0);
      nop(1);
      chk("coll_nopend", fif.If_PC, 32'h11C);

      // Drive both counters into saturation
      for (int i = 0; i < CMAX + 20; i++) begin
         step(0, mk_br(i[0], 16'($urandom)), 0, 0);
         nop(1);
      end
      chk("sat_br", 32'(br_cnt), CMAX);
      chk("sat_miss", 32'(miss_cnt), CMAX);

      mid_reset();
      for (int i = 0; i < 3; i++) begin
         chk("post_rst_seq", fif.If_PC, 32'(i * 4));
         nop(0);
      end

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(0, 5))
            0, 1:    inst = mk_br($urandom_range(0, 1) == 1, 16'($urandom));
            2:       inst = {6'd2, 26'($urandom)};
            3:       inst = {6'd3, 26'($urandom)};
            default: inst = {6'($urandom_range(6, 63)), 26'($urandom)};
         endcase
         step($urandom_range(0, 4) == 0, inst, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

IF-stage next-PC generator that consumes the 1-bit/2-bit direction predictor's `predTaken` and the ID-stage `predWrong` check. It computes sequential, branch-target and jump addresses, and steers fetch down the predicted path. It holds the alternate (not-chosen) address of the branch travelling into ID, so a misprediction recovers in one cycle. It also keeps saturating branch/mispredict counters for predictor experiments.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset
- `CNT_W`, default 16, width of the performance counters
- `clk` input 1: single clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `stall` input 1: hazard stall; freezes PC and the IF/ID-side registers
- `If_Inst` input 32: instruction fetched at `If_PC`
- `predTaken` input 1: direction prediction for the instruction in IF
- `predWrong` input 1: ID-stage check result for the branch in IF/ID
- `If_PC` output 32: current fetch address
- `IfId_PredTaken` output 1: registered prediction, for ID-stage check
- `flush` output 1: kill the instruction currently in IF (combinational)
- `br_cnt` output CNT_W: resolved branches, saturating
- `miss_cnt` output CNT_W: mispredicted branches, saturating

## Operation
- Opcode is `If_Inst[31:26]`. BEQ is 000100, BNE is 000101, J is 000010, JAL is 000011.
- Address terms:
  - seq = `If_PC`+4
  - btgt = seq + (sext(`If_Inst[15:0]`)<<2)
  - jtgt = {seq[31:28], `If_Inst[25:0]`, 2'b00}
- All adds are modulo 2^32; wrap past 32'hFFFF_FFFC to 0 silently.
- `resolve` = `pend_r` & !`stall`.
- `flush` = `resolve` & `predWrong`.
- `predWrong` is ignored when `pend_r`=0 or `stall`=1. The branch stays in ID and is re-checked the next cycle.
- Next-PC priority, highest first:
  1. `flush`: PC <- `alt_r`.
  2. `stall`: PC holds.
  3. J/JAL: PC <- jtgt.
  4. BEQ/BNE with `predTaken`=1: PC <- btgt.
  5. Otherwise: PC <- seq.
- Branch capture happens only when a BEQ/BNE is in IF, `stall`=0 and `flush`=0:
  - `pend_r` <- 1
  - `alt_r` <- (`predTaken` ? seq : btgt)
  - `IfId_PredTaken` <- `predTaken`
- In any other non-stall cycle, including a flush cycle, `pend_r` <- 0 and `IfId_PredTaken` <- 0. A flush therefore also kills a branch sitting in IF.
- `stall`=1 holds `pend_r`, `alt_r`, `IfId_PredTaken` and the PC.
- Counters update only when `resolve`=1:
  - `br_cnt` increments on every resolve.
  - `miss_cnt` increments on resolve with `predWrong`=1.
  - Both saturate at all-ones and never wrap.
- Back-to-back branches: a flush for branch N overrides the capture of branch N+1 in the same cycle. Branch N+1 is discarded.

## Timing
- Reset values:
  - `If_PC` = `RESET_PC`
  - `alt_r` = 0
  - `pend_r` = 0
  - `IfId_PredTaken` = 0
  - `br_cnt` = 0, `miss_cnt` = 0
  - `flush` = 0, because `pend_r`=0
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. The first fetch after deassertion is at `RESET_PC`.
- Redirect latency is 1 cycle. The predicted target appears on `If_PC` the cycle after the branch is in IF.
- Mispredict recovery is 1 cycle. `flush` is high in the resolve cycle, and `If_PC`=`alt_r` on the next edge.
- Penalty is exactly one killed fetch per misprediction.
- `flush` has no register stage. It depends only on `pend_r`, `stall` and `predWrong`, never on `If_Inst`.

## Structure
- Shared package `mips_pkg`:
  - opcode localparams OP_BEQ, OP_BNE, OP_J, OP_JAL
  - PC width 32
  - instruction field slice constants
  - The predictor and check blocks switch to the same package.
- Sub-module `fetch_target_calc`: purely combinational. Takes `If_PC` and `If_Inst`; produces seq, btgt, jtgt, `is_branch` and `is_jump`.
- The top level holds the PC, `alt_r`, `pend_r`, `IfId_PredTaken` and the counters.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle. Expect `If_PC`=`RESET_PC` immediately and all counters 0; after release, the PC steps 0, 4, 8.
- Predicted-taken BEQ, correct: at PC 0x10, imm 0x0003, `predTaken`=1. Expect next `If_PC`=0x20 and `IfId_PredTaken`=1. With `predWrong`=0, expect `flush`=0, `br_cnt`=1, `miss_cnt`=0.
- Predicted-not-taken BNE, wrong: at PC 0x40, imm 0xFFFE, `predTaken`=0. Expect next PC 0x44. Then `predWrong`=1: expect `flush`=1 and next PC 0x3C (0x44-8), `miss_cnt`=1.
- Stall during resolve: `pend_r`=1, `stall`=1, `predWrong`=1 for 2 cycles. Expect `flush`=0, PC frozen, counters unchanged. Then `stall`=0 with `predWrong`=1: expect one flush.
- J and flush collision:
  - J at PC 0x100 with index 0x40. Expect next PC 0x100.
  - A branch in IF while the prior branch mispredicts. Expect PC=`alt_r`, `pend_r`=0 and no capture of the new branch.
- Saturation: preload counters to all-ones via 2^16 resolves. A further mispredict keeps `br_cnt`=`miss_cnt`=0xFFFF.
